serdes_noise_injector: RTL
==========================

# serdes_noise_injector

Synthesizable, parametrised channel-impairment block inserted in the SerDes loopback path between `eth_phy_10g` transmit outputs and receive inputs. It corrupts sync headers or data bits with programmable probability: random, burst or single-bit-flip. It counts valid and invalid headers over a fixed window and measures blocks-to-block-lock, so BER-vs-lock sweeps run in hardware or in any bench without behavioural randomness.

## Interface
- `DATA_WIDTH`, 64: block data width; must be a power of two.
- `HDR_WIDTH`, 2: sync header width.
- `LFSR_WIDTH`, 32: width of the random source and of `cfg_threshold`.
- `CNT_WIDTH`, 32: width of all status counters; every counter saturates.
- `WINDOW_BLOCKS`, 500: number of blocks in one measurement window.
- `BURST_WIDTH`, 8: width of `cfg_burst_len`.

Ports:
- `rx_clk` in 1: single clock, one block per cycle.
- `rx_rst_n` in 1: asynchronous, active-low reset.
- `in_data` in DATA_WIDTH: block data from the transmitter (`serdes_tx_data`).
- `in_hdr` in HDR_WIDTH: sync header from the transmitter.
- `out_data` out DATA_WIDTH: impaired data to the receiver (`serdes_rx_data`).
- `out_hdr` out HDR_WIDTH: impaired header to the receiver.
- `rx_block_lock` in 1: block-lock status from the PHY receiver.
- `cfg_enable` in 1: starts or stops a measurement run.
- `cfg_mode` in 2: 0 pass-through, 1 random header, 2 burst header, 3 data bit flip.
- `cfg_threshold` in LFSR_WIDTH: corruption probability ≈ threshold/2^LFSR_WIDTH.
- `cfg_burst_len` in BURST_WIDTH: length of a burst in blocks; 0 is treated as 1.
- `cfg_seed` in LFSR_WIDTH: LFSR seed value.
- `cfg_seed_load` in 1: one-cycle pulse that loads the seed.
- `stat_hdr_valid` out CNT_WIDTH: number of output headers that are 01 or 10.
- `stat_hdr_invalid` out CNT_WIDTH: number of output headers that are 00 or 11.
- `stat_lock_blocks` out CNT_WIDTH: blocks from run start to the first `rx_block_lock` rise.
- `stat_lock_seen` out 1: lock rise observed during the current run.
- `stat_window_done` out 1: `WINDOW_BLOCKS` blocks have been counted.

## Operation
- LFSR: Galois, polynomial x^32+x^22+x^2+x+1 for the default width.
  - Advances every cycle in every state.
  - `cfg_seed_load` loads `cfg_seed`; a zero seed loads 1 instead.
  - Reset value is 1.
- Hit condition: `hit = (lfsr <= cfg_threshold)`, evaluated on the current LFSR value.
  - The LFSR is never zero, so threshold 0 gives no hits and all-ones gives a hit every cycle.
- Header corruption replaces the header with all-ones (11).
- Data bit flip XORs `in_data` with a one-hot mask at bit index `lfsr[log2(DATA_WIDTH)-1:0]`. The header passes unchanged.
- FSM:
  - IDLE: pass-through; counters hold their values. When `cfg_enable`=1, clear all stats and go to RUN.
  - RUN: `cfg_mode` and `cfg_threshold` are sampled live each cycle.
    - Modes 1 and 3: corrupt this block if `hit`.
    - Mode 2: on `hit`, corrupt this block, latch `max(cfg_burst_len,1)-1` remaining blocks and go to BURST (or stay in RUN if 0 remain).
  - BURST: corrupt every block; decrement the remaining count; return to RUN after the last burst block.
  - DONE: entered when the window completes. Pass-through, stats frozen; `cfg_enable`=0 returns to IDLE.
  - `cfg_enable`=0 in RUN or BURST returns to IDLE immediately. Stats hold their values.
- Counting, in RUN and BURST only:
  - Each output header increments `stat_hdr_valid` or `stat_hdr_invalid`.
  - When the sum reaches `WINDOW_BLOCKS`, set `stat_window_done` and enter DONE.
- Lock measurement:
  - `stat_lock_blocks` increments each RUN/BURST cycle while `stat_lock_seen`=0.
  - On the first cycle with `rx_block_lock`=1 and the previous sample 0 (or lock already high at run start), set `stat_lock_seen` and freeze the count.
  - A later lock loss does not clear `stat_lock_seen`.

## Timing
- Datapath latency is 1 cycle: `out_*` at cycle n+1 reflect `in_*` at cycle n and the corruption decision made at n.
- The corruption decision uses the LFSR value of the cycle in which the input is sampled.
- Reset (asynchronous, immediate):
  - `out_data`=0, `out_hdr`=0.
  - All stats 0, `stat_lock_seen`=0, `stat_window_done`=0.
  - FSM in IDLE, LFSR=1, burst counter 0.
- Reset mid-burst aborts the burst. No corruption occurs after `rx_rst_n` is released until RUN is re-entered.
- Stats update in the same edge as the registered output they describe.
- Saturating counters stop at all-ones and never wrap.
- A seed load and a hit in the same cycle: the hit uses the old LFSR value; the new seed takes effect next cycle.
- A burst in progress when the window completes is truncated; DONE has priority.

## Test plan
- Mode 1, threshold 0, 600 blocks alternating hdr 10/01 → output equals input delayed 1 cycle; `stat_hdr_valid`=500, `stat_hdr_invalid`=0, `stat_window_done`=1.
- Mode 1, threshold 0xFFFFFFFF → every output header 11; `stat_hdr_invalid`=500; `stat_lock_seen`=0 with the PHY in loopback.
- Mode 1, threshold 0x13758000 (≈0.076), seed 0xACE1 → `stat_hdr_invalid` matches a bit-exact reference LFSR model; the lock result is reported.
- Mode 2, burst_len 4, threshold 0xFFFFFFFF for 1 cycle then 0 → exactly 4 consecutive 11 headers, then RUN.
- Mode 3, threshold max → exactly one data bit differs per block at the LFSR-indexed position; headers untouched.
- Assert `rx_rst_n` low mid-burst, then release → outputs 0 asynchronously, stats 0, FSM in IDLE; re-enable restarts the count from 0.

Source files
------------

// File: rtl/serdes_noise_injector.sv
// serdes_noise_injector
// Channel-impairment block for the SerDes loopback path. Each cycle it takes one
// block (data + sync header) from the transmitter. It can corrupt the block using a
// programmable LFSR-based probability, then forwards it to the receiver one cycle later.
// It also gathers header statistics over a fixed window and measures how many blocks
// pass before the PHY reports block lock.
//
// Ports:
//   rx_clk, rx_rst_n            clock, asynchronous active-low reset
//   in_data, in_hdr             block from the transmitter
//   out_data, out_hdr           impaired block to the receiver (registered)
//   rx_block_lock               block-lock status from the PHY receiver
//   cfg_enable                  starts (1) / aborts or closes (0) a measurement run
//   cfg_mode                    0 pass, 1 random header, 2 burst header, 3 data bit flip
//   cfg_threshold               hit when lfsr <= threshold
//   cfg_burst_len               burst length in blocks (0 acts as 1)
//   cfg_seed, cfg_seed_load     LFSR seed and one-cycle load strobe
//   stat_hdr_valid/_invalid     header counters over the window (saturating)
//   stat_lock_blocks            blocks from run start to first lock rise
//   stat_lock_seen              lock rise observed in this run
//   stat_window_done            the window has completed
module serdes_noise_injector #(
    parameter int DATA_WIDTH    = 64,
    parameter int HDR_WIDTH     = 2,
    parameter int LFSR_WIDTH    = 32,
    parameter int CNT_WIDTH     = 32,
    parameter int WINDOW_BLOCKS = 500,
    parameter int BURST_WIDTH   = 8,
    // Galois tap mask for x^32+x^22+x^2+x+1 (bits 31, 21, 1, 0)
    parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS = LFSR_WIDTH'(32'h8020_0003)
) (
    input  logic                   rx_clk,
    input  logic                   rx_rst_n,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [HDR_WIDTH-1:0]   in_hdr,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [HDR_WIDTH-1:0]   out_hdr,
    input  logic                   rx_block_lock,
    input  logic                   cfg_enable,
    input  logic [1:0]             cfg_mode,
    input  logic [LFSR_WIDTH-1:0]  cfg_threshold,
    input  logic [BURST_WIDTH-1:0] cfg_burst_len,
    input  logic [LFSR_WIDTH-1:0]  cfg_seed,
    input  logic                   cfg_seed_load,
    output logic [CNT_WIDTH-1:0]   stat_hdr_valid,
    output logic [CNT_WIDTH-1:0]   stat_hdr_invalid,
    output logic [CNT_WIDTH-1:0]   stat_lock_blocks,
    output logic                   stat_lock_seen,
    output logic                   stat_window_done
);

    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam logic [LFSR_WIDTH-1:0]  LFSR_ONE  = {{(LFSR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0]  DATA_ONE  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]   CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH:0]     SUM_ONE   = {{CNT_WIDTH{1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH:0]     WIN_LIM   = (CNT_WIDTH+1)'(WINDOW_BLOCKS);
    localparam logic [BURST_WIDTH-1:0] BURST_ZERO = {BURST_WIDTH{1'b0}};
    localparam logic [BURST_WIDTH-1:0] BURST_ONE  = {{(BURST_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [HDR_WIDTH-1:0]   HDR_BAD    = {HDR_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BURST = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Saturating increment: stops at all-ones
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        sat_inc = (&v) ? v : (v + CNT_ONE);
    endfunction

    // A sync header is valid when it is 01 or 10
    function automatic logic hdr_is_valid(input logic [HDR_WIDTH-1:0] h);
        hdr_is_valid = (h == {{(HDR_WIDTH-1){1'b0}}, 1'b1}) ||
                       (h == {1'b1, {(HDR_WIDTH-1){1'b0}}});
    endfunction

    // One Galois LFSR step (right shift, taps applied when the shifted-out bit is 1)
    function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] v);
        lfsr_step = v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

    state_t                 state_r;
    logic [LFSR_WIDTH-1:0]  lfsr_r;
    logic [BURST_WIDTH-1:0] burst_cnt_r;
    logic                   lock_prev_r;
    logic [DATA_WIDTH-1:0]  out_data_r;
    logic [HDR_WIDTH-1:0]   out_hdr_r;
    logic [CNT_WIDTH-1:0]   hdr_valid_r;
    logic [CNT_WIDTH-1:0]   hdr_invalid_r;
    logic [CNT_WIDTH-1:0]   lock_blocks_r;
    logic                   lock_seen_r;
    logic                   window_done_r;

    logic                   active_s;
    logic                   hit_s;
    logic                   burst_start_s;
    logic [DATA_WIDTH-1:0]  data_next_s;
    logic [HDR_WIDTH-1:0]   hdr_next_s;
    logic [BURST_WIDTH-1:0] burst_len_m1_s;
    logic [CNT_WIDTH:0]     sum_next_s;
    logic                   window_hit_s;

    assign active_s       = ((state_r == ST_RUN) || (state_r == ST_BURST)) && cfg_enable;
    assign hit_s          = (lfsr_r <= cfg_threshold);
    assign burst_len_m1_s = (cfg_burst_len == BURST_ZERO) ? BURST_ZERO : (cfg_burst_len - BURST_ONE);
    assign sum_next_s     = {1'b0, hdr_valid_r} + {1'b0, hdr_invalid_r} + SUM_ONE;
    assign window_hit_s   = (sum_next_s >= WIN_LIM);

    // Corruption decision for the block sampled this cycle
    always_comb begin
        data_next_s   = in_data;
        hdr_next_s    = in_hdr;
        burst_start_s = 1'b0;
        if (active_s) begin
            case (state_r)
                ST_BURST: hdr_next_s = HDR_BAD;
                ST_RUN: begin
                    case (cfg_mode)
                        2'd1: begin
                            if (hit_s) hdr_next_s = HDR_BAD;
                            else       hdr_next_s = in_hdr;
                        end
                        2'd2: begin
                            if (hit_s) begin
                                hdr_next_s    = HDR_BAD;
                                burst_start_s = 1'b1;
                            end else begin
                                hdr_next_s    = in_hdr;
                            end
                        end
                        2'd3: begin
                            if (hit_s) data_next_s = in_data ^ (DATA_ONE << lfsr_r[IDX_W-1:0]);
                            else       data_next_s = in_data;
                        end
                        default: data_next_s = in_data;
                    endcase
                end
                default: hdr_next_s = in_hdr;
            endcase
        end else begin
            data_next_s = in_data;
        end
    end

    // LFSR, registered datapath, run-control FSM and statistics
    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            state_r       <= ST_IDLE;
            lfsr_r        <= LFSR_ONE;
            burst_cnt_r   <= BURST_ZERO;
            lock_prev_r   <= 1'b0;
            out_data_r    <= {DATA_WIDTH{1'b0}};
            out_hdr_r     <= {HDR_WIDTH{1'b0}};
            hdr_valid_r   <= {CNT_WIDTH{1'b0}};
            hdr_invalid_r <= {CNT_WIDTH{1'b0}};
            lock_blocks_r <= {CNT_WIDTH{1'b0}};
            lock_seen_r   <= 1'b0;
            window_done_r <= 1'b0;
        end else begin
            // A seed load replaces this cycle's advance; zero would lock the LFSR up
            if (cfg_seed_load) begin
                lfsr_r <= (cfg_seed == {LFSR_WIDTH{1'b0}}) ? LFSR_ONE : cfg_seed;
            end else begin
                lfsr_r <= lfsr_step(lfsr_r);
            end
            out_data_r  <= data_next_s;
            out_hdr_r   <= hdr_next_s;
            lock_prev_r <= rx_block_lock;

            case (state_r)
                ST_IDLE: begin
                    if (cfg_enable) begin
                        hdr_valid_r   <= {CNT_WIDTH{1'b0}};
                        hdr_invalid_r <= {CNT_WIDTH{1'b0}};
                        lock_blocks_r <= {CNT_WIDTH{1'b0}};
                        lock_seen_r   <= 1'b0;
                        window_done_r <= 1'b0;
                        burst_cnt_r   <= BURST_ZERO;
                        // Lock already high at run start counts as a rise
                        lock_prev_r   <= 1'b0;
                        state_r       <= ST_RUN;
                    end else begin
                        state_r       <= ST_IDLE;
                    end
                end
                ST_RUN, ST_BURST: begin
                    if (!cfg_enable) begin
                        burst_cnt_r <= BURST_ZERO;
                        state_r     <= ST_IDLE;
                    end else begin
                        if (hdr_is_valid(hdr_next_s)) hdr_valid_r   <= sat_inc(hdr_valid_r);
                        else                          hdr_invalid_r <= sat_inc(hdr_invalid_r);

                        if (!lock_seen_r) begin
                            if (rx_block_lock && !lock_prev_r) lock_seen_r   <= 1'b1;
                            else                               lock_blocks_r <= sat_inc(lock_blocks_r);
                        end else begin
                            lock_seen_r <= 1'b1;
                        end

                        // Window completion truncates any burst in progress
                        if (window_hit_s) begin
                            window_done_r <= 1'b1;
                            burst_cnt_r   <= BURST_ZERO;
                            state_r       <= ST_DONE;
                        end else if (state_r == ST_RUN) begin
                            if (burst_start_s && (burst_len_m1_s != BURST_ZERO)) begin
                                burst_cnt_r <= burst_len_m1_s;
                                state_r     <= ST_BURST;
                            end else begin
                                state_r     <= ST_RUN;
                            end
                        end else begin
                            if (burst_cnt_r <= BURST_ONE) begin
                                burst_cnt_r <= BURST_ZERO;
                                state_r     <= ST_RUN;
                            end else begin
                                burst_cnt_r <= burst_cnt_r - BURST_ONE;
                                state_r     <= ST_BURST;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (!cfg_enable) state_r <= ST_IDLE;
                    else             state_r <= ST_DONE;
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign out_data         = out_data_r;
    assign out_hdr          = out_hdr_r;
    assign stat_hdr_valid   = hdr_valid_r;
    assign stat_hdr_invalid = hdr_invalid_r;
    assign stat_lock_blocks = lock_blocks_r;
    assign stat_lock_seen   = lock_seen_r;
    assign stat_window_done = window_done_r;

endmodule
